adc_serial2parallel: RTL and testbench

//  Receive-side counterpart of the DAC serializer: deserializes the audio codec ADC

---
 rtl/adc_serial2parallel.sv | 119 +++++++++++
 tb/tb_adc_serial2parallel.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/adc_serial2parallel.sv
// rtl/adc_serial2parallel.sv - codec ADC left-justified serial stream to parallel sample deserializer
module adc_serial2parallel #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  left_channel,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] ADCDATA,
    output logic                  ADCDATA_VALID,
    input  logic                  ADCDATA_ACK,
    output logic                  ADC_OVERRUN
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {ST_SYNC, ST_ARMED, ST_SHIFT, ST_HOLD} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  bclk_sync;
    logic [SYNC_STAGES-1:0]  lrck_sync;
    logic [SYNC_STAGES-1:0]  dat_sync;
    logic                    bclk_prev;
    logic [DATA_WIDTH-2:0]   shift_reg;
    logic [CW-1:0]           bit_cnt;

    logic                    bclk_s;
    logic                    lrck_s;
    logic                    dat_s;
    logic                    bclk_rise;
    logic                    act;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic                    word_done;

    assign bclk_s     = bclk_sync[SYNC_STAGES-1];
    assign lrck_s     = lrck_sync[SYNC_STAGES-1];
    assign dat_s      = dat_sync[SYNC_STAGES-1];
    assign bclk_rise  = bclk_s & ~bclk_prev;
    assign act        = left_channel ? ~lrck_s : lrck_s;
    assign shift_next = {shift_reg, dat_s};
    assign word_done  = (state == ST_SHIFT) && act && bclk_rise && (bit_cnt == LAST_BIT);

    // Identical chains keep BCLK, LRCK and DAT aligned relative to each other.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
            bclk_prev <= bclk_s;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_SYNC;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            ADCDATA       <= '0;
            ADCDATA_VALID <= 1'b0;
            ADC_OVERRUN   <= 1'b0;
        end else begin
            if (ADCDATA_VALID && ADCDATA_ACK) begin
                ADCDATA_VALID <= 1'b0;
            end

            // A completed word overrides the ack-clear above in the same cycle.
            if (word_done) begin
                ADCDATA       <= shift_next;
                ADCDATA_VALID <= 1'b1;
                if (ADCDATA_VALID && !ADCDATA_ACK) begin
                    ADC_OVERRUN <= 1'b1;
                end
            end

            case (state)
                ST_SYNC: begin
                    if (!act) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (act) begin
                        state     <= ST_SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (!act) begin
                        state <= ST_ARMED;
                    end else if (bclk_rise) begin
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_HOLD;
                        end else begin
                            shift_reg <= shift_next[DATA_WIDTH-2:0];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!act) begin
                        state <= ST_ARMED;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial2parallel.sv
// tb/tb_adc_serial2parallel.sv - directed scoreboard bench for adc_serial2parallel
module tb_adc_serial2parallel;

    logic        CLOCK_50;
    logic        resetn;
    logic        left_channel;
    logic        AUD_BCLK;
    logic        AUD_ADCLRCK;
    logic        AUD_ADCDAT;
    logic [15:0] ADCDATA;
    logic        ADCDATA_VALID;
    logic        ADCDATA_ACK;
    logic        ADC_OVERRUN;

    int          vectors;
    int          miscompares;
    logic [15:0] sb[$];

    adc_serial2parallel #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .left_channel  (left_channel),
        .AUD_BCLK      (AUD_BCLK),
        .AUD_ADCLRCK   (AUD_ADCLRCK),
        .AUD_ADCDAT    (AUD_ADCDAT),
        .ADCDATA       (ADCDATA),
        .ADCDATA_VALID (ADCDATA_VALID),
        .ADCDATA_ACK   (ADCDATA_ACK),
        .ADC_OVERRUN   (ADC_OVERRUN)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One half-frame at 3.125 MHz BCLK (8 clocks high, 8 low); optional ACK lands on the LSB completion edge.
    task automatic send_half(input logic lv, input int n, input logic [31:0] word, input bit ack_lsb);
        AUD_ADCLRCK = lv;
        for (int i = 0; i < n; i++) begin
            AUD_ADCDAT = word[n-1-i];
            #160;
            AUD_BCLK = 1'b1;
            if (ack_lsb && i == 15) begin
                #40;
                ADCDATA_ACK = 1'b1;
                #20;
                ADCDATA_ACK = 1'b0;
                #100;
            end else begin
                #160;
            end
            AUD_BCLK = 1'b0;
        end
    endtask

    task automatic expect_word(input string tag);
        logic [15:0] exp;
        int          cyc;
        cyc = 0;
        while (!ADCDATA_VALID && cyc < 200) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        check({tag, "_valid"}, {31'd0, ADCDATA_VALID}, 32'd1);
        exp = 'x;
        if (sb.size() > 0) exp = sb.pop_front();
        check({tag, "_data"}, {16'd0, ADCDATA}, {16'd0, exp});
    endtask

    task automatic ack(input string tag);
        @(negedge CLOCK_50);
        ADCDATA_ACK = 1'b1;
        @(negedge CLOCK_50);
        ADCDATA_ACK = 1'b0;
        check({tag, "_cleared"}, {31'd0, ADCDATA_VALID}, 32'd0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        resetn       = 1'b0;
        left_channel = 1'b1;
        AUD_BCLK     = 1'b0;
        AUD_ADCLRCK  = 1'b1;
        AUD_ADCDAT   = 1'b0;
        ADCDATA_ACK  = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_data", {16'd0, ADCDATA}, 32'd0);
        check("rst_valid", {31'd0, ADCDATA_VALID}, 32'd0);
        check("rst_ovr", {31'd0, ADC_OVERRUN}, 32'd0);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        // 1: left channel, single word then ACK
        send_half(1'b1, 16, 32'h0000, 1'b0);
        sb.push_back(16'hA5C3);
        send_half(1'b0, 16, 32'hA5C3, 1'b0);
        send_half(1'b1, 16, 32'h5555, 1'b0);
        expect_word("t1");
        check("t1_ovr", {31'd0, ADC_OVERRUN}, 32'd0);
        ack("t1");
        ack("t1_idle_ack");
        check("t1_idle_data", {16'd0, ADCDATA}, 32'h0000A5C3);

        // 2: right channel only
        left_channel = 1'b0;
        send_half(1'b0, 16, 32'h1234, 1'b0);
        sb.push_back(16'h8001);
        send_half(1'b1, 16, 32'h8001, 1'b0);
        send_half(1'b0, 16, 32'h1234, 1'b0);
        expect_word("t2");
        ack("t2");

        // 3: overrun, sticky
        sb.push_back(16'h0001);
        send_half(1'b1, 16, 32'h0001, 1'b0);
        send_half(1'b0, 16, 32'h0000, 1'b0);
        expect_word("t3_first");
        check("t3_no_ovr_yet", {31'd0, ADC_OVERRUN}, 32'd0);
        sb.push_back(16'hFFFF);
        send_half(1'b1, 16, 32'hFFFF, 1'b0);
        send_half(1'b0, 16, 32'h0000, 1'b0);
        expect_word("t3_second");
        check("t3_ovr", {31'd0, ADC_OVERRUN}, 32'd1);
        ack("t3");
        check("t3_ovr_sticky", {31'd0, ADC_OVERRUN}, 32'd1);

        @(negedge CLOCK_50);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        check("rst2_ovr", {31'd0, ADC_OVERRUN}, 32'd0);
        check("rst2_valid", {31'd0, ADCDATA_VALID}, 32'd0);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        // 4: ACK coincides with second word completion
        sb.push_back(16'h1111);
        send_half(1'b1, 16, 32'h1111, 1'b0);
        send_half(1'b0, 16, 32'h0000, 1'b0);
        expect_word("t4_first");
        sb.push_back(16'h2222);
        send_half(1'b1, 16, 32'h2222, 1'b1);
        expect_word("t4_second");
        check("t4_ovr", {31'd0, ADC_OVERRUN}, 32'd0);
        ack("t4");
        send_half(1'b0, 16, 32'h0000, 1'b0);

        // 5: reset released inside an active half-frame
        resetn       = 1'b0;
        left_channel = 1'b1;
        send_half(1'b0, 5, 32'h15, 1'b0);
        resetn = 1'b1;
        send_half(1'b0, 11, 32'h2AA, 1'b0);
        check("t5_partial_valid", {31'd0, ADCDATA_VALID}, 32'd0);
        send_half(1'b1, 16, 32'h0000, 1'b0);
        sb.push_back(16'h7FFF);
        send_half(1'b0, 16, 32'h7FFF, 1'b0);
        send_half(1'b1, 16, 32'h0000, 1'b0);
        expect_word("t5");
        ack("t5");

        // 6: aborted short frame, then 24-bit frame truncated to 16
        send_half(1'b0, 9, 32'h1FF, 1'b0);
        send_half(1'b1, 16, 32'h0000, 1'b0);
        check("t6_abort_valid", {31'd0, ADCDATA_VALID}, 32'd0);
        sb.push_back(16'hBEEF);
        send_half(1'b0, 24, 32'hBEEF00, 1'b0);
        send_half(1'b1, 16, 32'h0000, 1'b0);
        expect_word("t6");
        ack("t6");
        check("end_ovr", {31'd0, ADC_OVERRUN}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
